// File: rtl/ifetch_byte_bus.sv
// ifetch_byte_bus: instruction-fetch initiator on the shared 8-bit pin bus.
// Sends the word-addressed PC as two address bytes, collects two data bytes
// and returns the assembled 16-bit instruction to the core.
// Optional build macro: IFETCH_PREFETCH_EN adds a one-entry sequential
// prefetch buffer (pc+1 fetched after every response handshake).
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are 1. Request side: req_valid/req_ready, req_ready is 1 only in IDLE
// and requests seen while it is 0 are dropped, not queued. Response side:
// instr_valid/instr_ready, once instr_valid is 1 it and instr_data/instr_err
// stay stable until the edge where instr_ready is 1.
module ifetch_byte_bus #(
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] ERR_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_pc,
  output logic        req_ready,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_data,
  output logic        instr_err,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  input  logic [7:0]  bus_in,
  input  logic        bus_rdy,
  output logic [1:0]  bus_phase,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   data_d;
  logic          err_d;
  logic          req_ready_d, instr_valid_d, bus_oe_d, busy_d;
  logic [7:0]    bus_out_d;
  logic [1:0]    bus_phase_d;

`ifdef IFETCH_PREFETCH_EN
  // pf_active marks that the fetch in flight is the autonomous pc+1 prefetch
  logic          pf_active_q, pf_active_d;
  logic          pf_valid_q, pf_valid_d;
  logic [15:0]   pf_pc_q, pf_pc_d;
  logic [15:0]   pf_data_q, pf_data_d;
`endif

  assign dbg_state = state_q;

  // Next-state, datapath updates and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    data_d  = instr_data;
    err_d   = instr_err;
`ifdef IFETCH_PREFETCH_EN
    pf_active_d = pf_active_q;
    pf_valid_d  = pf_valid_q;
    pf_pc_d     = pf_pc_q;
    pf_data_d   = pf_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          pc_d = req_pc;
`ifdef IFETCH_PREFETCH_EN
          // The buffer is consumed on a hit and discarded on a miss
          pf_valid_d = 1'b0;
          if (pf_valid_q && (req_pc == pf_pc_q)) begin
            state_d = S_RESP;
            data_d  = pf_data_q;
            err_d   = 1'b0;
          end else begin
            state_d = S_ADDR_HI;
          end
`else
          state_d = S_ADDR_HI;
`endif
        end
      end

      S_ADDR_HI: state_d = S_ADDR_LO;

      S_ADDR_LO: begin
        state_d = S_DATA_HI;
        cnt_d   = '0;
      end

      S_DATA_HI, S_DATA_LO: begin
        if (bus_rdy) begin
          // A ready byte wins over a timeout landing in the same cycle
          cnt_d = '0;
          if (state_q == S_DATA_HI) begin
            state_d = S_DATA_LO;
`ifdef IFETCH_PREFETCH_EN
            if (pf_active_q) pf_data_d[15:8] = bus_in;
            else             data_d[15:8]    = bus_in;
`else
            data_d[15:8] = bus_in;
`endif
          end else begin
`ifdef IFETCH_PREFETCH_EN
            if (pf_active_q) begin
              pf_data_d[7:0] = bus_in;
              pf_valid_d     = 1'b1;
              pf_pc_d        = pc_q;
              pf_active_d    = 1'b0;
              state_d        = S_IDLE;
            end else begin
              data_d[7:0] = bus_in;
              err_d       = 1'b0;
              state_d     = S_RESP;
            end
`else
            data_d[7:0] = bus_in;
            err_d       = 1'b0;
            state_d     = S_RESP;
`endif
          end
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
`ifdef IFETCH_PREFETCH_EN
          if (pf_active_q) begin
            // A failed prefetch is simply dropped; the buffer stays empty
            pf_active_d = 1'b0;
            pf_valid_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            data_d  = ERR_INSTR;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`else
          data_d  = ERR_INSTR;
          err_d   = 1'b1;
          state_d = S_RESP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (instr_ready) begin
`ifdef IFETCH_PREFETCH_EN
          state_d     = S_ADDR_HI;
          pc_d        = pc_q + 16'd1;
          pf_active_d = 1'b1;
`else
          state_d = S_IDLE;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state
    req_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    instr_valid_d = (state_d == S_RESP);
    bus_oe_d      = 1'b0;
    bus_out_d     = 8'h00;
    bus_phase_d   = 2'b00;
    case (state_d)
      S_ADDR_HI: begin
        bus_oe_d    = 1'b1;
        bus_out_d   = pc_d[15:8];
        bus_phase_d = 2'b00;
      end
      S_ADDR_LO: begin
        bus_oe_d    = 1'b1;
        bus_out_d   = pc_d[7:0];
        bus_phase_d = 2'b01;
      end
      S_DATA_HI: bus_phase_d = 2'b10;
      S_DATA_LO: bus_phase_d = 2'b11;
      default:   bus_phase_d = 2'b00;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= 16'h0000;
      cnt_q       <= '0;
      instr_data  <= 16'h0000;
      instr_err   <= 1'b0;
      instr_valid <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      bus_oe      <= 1'b0;
      bus_out     <= 8'h00;
      bus_phase   <= 2'b00;
`ifdef IFETCH_PREFETCH_EN
      pf_active_q <= 1'b0;
      pf_valid_q  <= 1'b0;
      pf_pc_q     <= 16'h0000;
      pf_data_q   <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      instr_data  <= data_d;
      instr_err   <= err_d;
      instr_valid <= instr_valid_d;
      req_ready   <= req_ready_d;
      busy        <= busy_d;
      bus_oe      <= bus_oe_d;
      bus_out     <= bus_out_d;
      bus_phase   <= bus_phase_d;
`ifdef IFETCH_PREFETCH_EN
      pf_active_q <= pf_active_d;
      pf_valid_q  <= pf_valid_d;
      pf_pc_q     <= pf_pc_d;
      pf_data_q   <= pf_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifetch_byte_bus.sv
// Testbench for ifetch_byte_bus: directed and randomized fetches checked
// against a transaction-level model of the fetch (address bytes, wait
// states, timeout, response word).
module tb_ifetch_byte_bus;

  localparam int          TIMEOUT   = 15;
  localparam logic [15:0] ERR_INSTR = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_pc;
  logic        req_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic        instr_err;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [7:0]  bus_in;
  logic        bus_rdy;
  logic [1:0]  bus_phase;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  // Scoreboard: {instr_err, instr_data} expected for each fetch
  logic [16:0] exp_q[$];

  ifetch_byte_bus #(.TIMEOUT(TIMEOUT), .ERR_INSTR(ERR_INSTR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_err(instr_err),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .bus_rdy(bus_rdy),
    .bus_phase(bus_phase), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: a byte wait of w cycles costs w+1 data-phase cycles;
  // more than TIMEOUT waits in either phase yields the error response.
  task automatic model_fetch(input int w_hi, input int w_lo,
                             input logic [7:0] hi, input logic [7:0] lo,
                             output logic [16:0] word);
    if (w_hi > TIMEOUT || w_lo > TIMEOUT) word = {1'b1, ERR_INSTR};
    else                                  word = {1'b0, hi, lo};
  endtask

  task automatic wait_req_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("wait_req_ready", req_ready, 1'b1);
  endtask

  // Drive one data phase: w wait cycles then the byte (or no byte at all
  // when w exceeds TIMEOUT, giving TIMEOUT+1 cycles before the error).
  task automatic data_phase(input string tag, input logic [1:0] ph,
                            input int w, input logic [7:0] b);
    int nc = (w > TIMEOUT) ? TIMEOUT + 1 : w + 1;
    for (int k = 0; k < nc; k++) begin
      bus_rdy = (k == w);
      bus_in  = (k == w) ? b : 8'($urandom);
      chk({tag, "_phase"}, bus_phase, ph);
      chk({tag, "_oe"}, bus_oe, 1'b0);
      chk({tag, "_valid"}, instr_valid, 1'b0);
      step();
    end
    bus_rdy = 1'b0;
  endtask

  task automatic run_fetch(input logic [15:0] pc, input logic [7:0] hi, input logic [7:0] lo,
                           input int w_hi, input int w_lo, input int hold);
    logic [16:0] word;
    logic [16:0] got;
    model_fetch(w_hi, w_lo, hi, lo, word);
    exp_q.push_back(word);
    wait_req_ready();
    req_valid = 1'b1;
    req_pc    = pc;
    bus_rdy   = 1'($urandom_range(0, 1));
    bus_in    = 8'($urandom);
    step();
    req_valid = 1'b0;
    req_pc    = 16'($urandom);
    chk("addr_hi_oe", bus_oe, 1'b1);
    chk("addr_hi_out", bus_out, pc[15:8]);
    chk("addr_hi_phase", bus_phase, 2'b00);
    chk("addr_hi_busy", busy, 1'b1);
    chk("addr_hi_req_ready", req_ready, 1'b0);
    bus_rdy = 1'($urandom_range(0, 1));
    bus_in  = 8'($urandom);
    step();
    chk("addr_lo_oe", bus_oe, 1'b1);
    chk("addr_lo_out", bus_out, pc[7:0]);
    chk("addr_lo_phase", bus_phase, 2'b01);
    bus_rdy = 1'($urandom_range(0, 1));
    bus_in  = 8'($urandom);
    step();
    data_phase("data_hi", 2'b10, w_hi, hi);
    if (w_hi <= TIMEOUT) data_phase("data_lo", 2'b11, w_lo, lo);
    got = exp_q.pop_front();
    chk("resp_valid", instr_valid, 1'b1);
    chk("resp_data", instr_data, got[15:0]);
    chk("resp_err", instr_err, got[16]);
    instr_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_pc    = 16'($urandom);
      step();
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_data", instr_data, got[15:0]);
      chk("hold_err", instr_err, got[16]);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    req_valid   = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("post_hs_valid", instr_valid, 1'b0);
`ifndef IFETCH_PREFETCH_EN
    chk("post_hs_req_ready", req_ready, 1'b1);
    chk("post_hs_busy", busy, 1'b0);
`endif
  endtask

`ifdef IFETCH_PREFETCH_EN
  // Service an autonomous prefetch that has just entered its address phase
  task automatic pf_fill(input logic [15:0] pc, input logic [7:0] hi, input logic [7:0] lo);
    chk("pf_busy", busy, 1'b1);
    chk("pf_req_ready", req_ready, 1'b0);
    chk("pf_addr_hi", bus_out, pc[15:8]);
    chk("pf_oe", bus_oe, 1'b1);
    step();
    chk("pf_addr_lo", bus_out, pc[7:0]);
    step();
    bus_rdy = 1'b1;
    bus_in  = hi;
    step();
    bus_in  = lo;
    step();
    bus_rdy = 1'b0;
    chk("pf_done_req_ready", req_ready, 1'b1);
  endtask
`endif

  // Directed sequence followed by randomized fetches
  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_pc      = 16'h0000;
    instr_ready = 1'b0;
    bus_in      = 8'h00;
    bus_rdy     = 1'b0;
    step();
    step();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_data", instr_data, 16'h0000);
    chk("rst_instr_err", instr_err, 1'b0);
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_bus_oe", bus_oe, 1'b0);
    chk("rst_bus_phase", bus_phase, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 3'd0);
    rst = 1'b0;

    // Basic fetch, wait states, timeouts and their boundaries, backpressure
    run_fetch(16'h1234, 8'hAB, 8'hCD, 0, 0, 0);
    run_fetch(16'h0F0F, 8'h5A, 8'hA5, 3, 2, 0);
    run_fetch(16'h2468, 8'h77, 8'h66, TIMEOUT + 1, 0, 0);
    run_fetch(16'h1357, 8'h12, 8'h34, TIMEOUT, 0, 0);
    run_fetch(16'h8001, 8'h9A, 8'hBC, 0, TIMEOUT + 1, 0);
    run_fetch(16'h8002, 8'hDE, 8'hF0, 0, TIMEOUT, 0);
    run_fetch(16'hBEEF, 8'hC0, 8'hDE, 1, 1, 4);

    // Reset during ADDR_LO aborts the fetch
    wait_req_ready();
    req_valid = 1'b1;
    req_pc    = 16'h4321;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_addr_lo_oe", bus_oe, 1'b1);
    chk("mid_addr_lo_phase", bus_phase, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_oe", bus_oe, 1'b0);
    chk("mid_rst_state", dbg_state, 3'd0);
    chk("mid_rst_valid", instr_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    run_fetch(16'h4321, 8'h43, 8'h21, 0, 0, 0);

    // Randomized fetches
    for (int i = 0; i < 20; i++) begin
      int wh = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 3));
      int wl = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 3));
      run_fetch(16'($urandom), 8'($urandom), 8'($urandom), wh, wl, int'($urandom_range(0, 3)));
    end

`ifdef IFETCH_PREFETCH_EN
    // Wrap prefetch hit, then a miss against a valid buffer
    run_fetch(16'hFFFF, 8'h11, 8'h22, 0, 0, 0);
    pf_fill(16'h0000, 8'h3C, 8'hC3);
    req_valid = 1'b1;
    req_pc    = 16'h0000;
    step();
    req_valid = 1'b0;
    chk("pf_hit_valid", instr_valid, 1'b1);
    chk("pf_hit_data", instr_data, 16'h3CC3);
    chk("pf_hit_err", instr_err, 1'b0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("pf_hit_post_valid", instr_valid, 1'b0);
    pf_fill(16'h0001, 8'h77, 8'h88);
    run_fetch(16'h0005, 8'h9E, 8'h6B, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
